bin2bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter for the display path. It runs the shift-and-add-3 (double-dabble) algorithm one bit per clock, so the combinational depth stays fixed as WIDTH grows. It adds a start/busy/done handshake, optional signed input, leading-zero blanking and an overflow flag. It sits between the arithmetic/counter logic and the seven-segment digit drivers, and holds its last result until the next conversion completes.

---
 rtl/bin2bcd_seq.sv | 148 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
// One magnitude bit is shifted into the BCD accumulator per clock. The design
// provides a start/busy/done handshake, optional two's complement input, a
// leading-zero blank mask and an overflow flag. Results are held until the
// next conversion completes.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter bit SIGNED = 1'b1,
    parameter bit BLANK  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd,
    output logic [3:0]            sgn,
    output logic [DIGITS-1:0]     blank,
    output logic                  ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIN
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [WIDTH-1:0]       shreg;
    logic [DIGITS*4-1:0]    acc;
    logic [DIGITS*4-1:0]    adj;
    logic [CW-1:0]          cnt;
    logic                   ovf_acc;
    logic                   neg_reg;

    logic                   neg;
    logic [WIDTH-1:0]       mag;
    logic [DIGITS-1:0]      blank_next;
    logic                   higher_zero;

    // The converter is busy from the accepting edge until the cycle before done.
    assign busy = (state != IDLE);

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: WIDTH shift cycles, then one cycle to publish results.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == CW'(WIDTH - 1)) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sign split: negative inputs become their WIDTH-bit two's complement
    // magnitude, so the most negative value still converts exactly.
    always_comb begin
        neg = SIGNED && bin[WIDTH-1];
        mag = neg ? (~bin + WIDTH'(1)) : bin;
    end

    // Add-3 correction for every digit >= 5, skipped while the accumulator is
    // still empty on the first shift.
    always_comb begin
        adj = acc;
        if (cnt != '0) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (acc[d*4 +: 4] >= 4'd5) begin
                    adj[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
                end
            end
        end
    end

    // Blank mask: a digit is blanked when it and all higher digits are zero;
    // digit 0 always shows and an overflowed result is never blanked.
    always_comb begin
        blank_next  = '0;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            higher_zero   = higher_zero && (acc[i*4 +: 4] == 4'd0);
            blank_next[i] = higher_zero;
        end
        if (!BLANK || ovf_acc) begin
            blank_next = '0;
        end
    end

    // Datapath: capture on start, shift during SHIFT, publish outputs in FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            neg_reg <= 1'b0;
            bcd     <= '0;
            sgn     <= 4'hF;
            blank   <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= mag;
                        neg_reg <= neg;
                        acc     <= '0;
                        cnt     <= '0;
                        ovf_acc <= 1'b0;
                    end
                end
                SHIFT: begin
                    acc     <= {adj[DIGITS*4-2:0], shreg[WIDTH-1]};
                    shreg   <= shreg << 1;
                    ovf_acc <= ovf_acc | adj[DIGITS*4-1];
                    cnt     <= cnt + CW'(1);
                end
                FIN: begin
                    bcd   <= acc;
                    sgn   <= neg_reg ? 4'hA : 4'hF;
                    ovf   <= ovf_acc;
                    blank <= blank_next;
                    done  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq.
// Four converter instances cover the signed default, unsigned 16-bit,
// 6-bit signed two-digit and 8-bit unsigned two-digit configurations.
// Stimulus pushes hand-computed results into per-instance queues; monitors
// pop and compare whenever an instance pulses done.
module tb_bin2bcd_seq;

    typedef struct packed {
        logic [19:0] bcd;
        logic [3:0]  sgn;
        logic [4:0]  blank;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst;

    logic        start_a, busy_a, done_a, ovf_a;
    logic [15:0] bin_a;
    logic [19:0] bcd_a;
    logic [3:0]  sgn_a;
    logic [4:0]  blank_a;

    logic        start_u, busy_u, done_u, ovf_u;
    logic [15:0] bin_u;
    logic [19:0] bcd_u;
    logic [3:0]  sgn_u;
    logic [4:0]  blank_u;

    logic        start_b, busy_b, done_b, ovf_b;
    logic [5:0]  bin_b;
    logic [7:0]  bcd_b;
    logic [3:0]  sgn_b;
    logic [1:0]  blank_b;

    logic        start_c, busy_c, done_c, ovf_c;
    logic [7:0]  bin_c;
    logic [7:0]  bcd_c;
    logic [3:0]  sgn_c;
    logic [1:0]  blank_c;

    exp_t q_a[$];
    exp_t q_u[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int checks = 0;
    int errors = 0;

    bin2bcd_seq dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a), .busy(busy_a),
        .done(done_a), .bcd(bcd_a), .sgn(sgn_a), .blank(blank_a), .ovf(ovf_a)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0), .BLANK(1'b1)) dut_u (
        .clk(clk), .rst(rst), .start(start_u), .bin(bin_u), .busy(busy_u),
        .done(done_u), .bcd(bcd_u), .sgn(sgn_u), .blank(blank_u), .ovf(ovf_u)
    );

    bin2bcd_seq #(.WIDTH(6), .DIGITS(2), .SIGNED(1'b1), .BLANK(1'b1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bin(bin_b), .busy(busy_b),
        .done(done_b), .bcd(bcd_b), .sgn(sgn_b), .blank(blank_b), .ovf(ovf_b)
    );

    bin2bcd_seq #(.WIDTH(8), .DIGITS(2), .SIGNED(1'b0), .BLANK(1'b1)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .bin(bin_c), .busy(busy_c),
        .done(done_c), .bcd(bcd_c), .sgn(sgn_c), .blank(blank_c), .ovf(ovf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [19:0] b, input logic [3:0] s,
                                input logic [4:0] bl, input logic o);
        exp_t e;
        e.bcd   = b;
        e.sgn   = s;
        e.blank = bl;
        e.ovf   = o;
        return e;
    endfunction

    function automatic logic doneOf(input int inst);
        case (inst)
            0:       return done_a;
            1:       return done_u;
            2:       return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic int widthOf(input int inst);
        case (inst)
            0, 1:    return 16;
            2:       return 6;
            default: return 8;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic compareResult(input string tag, input exp_t got,
                                 input logic got_busy, input exp_t want);
        checkOutput({tag, " bcd"},   32'(got.bcd),   32'(want.bcd));
        checkOutput({tag, " sgn"},   32'(got.sgn),   32'(want.sgn));
        checkOutput({tag, " blank"}, 32'(got.blank), 32'(want.blank));
        checkOutput({tag, " ovf"},   32'(got.ovf),   32'(want.ovf));
        checkOutput({tag, " busy during done"}, 32'(got_busy), 32'd0);
    endtask

    task automatic unexpectedDone(input string tag);
        checks++;
        errors++;
        $display("[TB] FAIL %s unexpected done: got 1, expected 0", tag);
    endtask

    // Monitors: each done pulse is matched against the oldest queued result.
    always @(negedge clk) begin
        if (done_a) begin
            if (q_a.size() == 0) unexpectedDone("A");
            else compareResult("A", mk(bcd_a, sgn_a, blank_a, ovf_a), busy_a, q_a.pop_front());
        end
        if (done_u) begin
            if (q_u.size() == 0) unexpectedDone("U");
            else compareResult("U", mk(bcd_u, sgn_u, blank_u, ovf_u), busy_u, q_u.pop_front());
        end
        if (done_b) begin
            if (q_b.size() == 0) unexpectedDone("B");
            else compareResult("B", mk(20'(bcd_b), sgn_b, 5'(blank_b), ovf_b), busy_b, q_b.pop_front());
        end
        if (done_c) begin
            if (q_c.size() == 0) unexpectedDone("C");
            else compareResult("C", mk(20'(bcd_c), sgn_c, 5'(blank_c), ovf_c), busy_c, q_c.pop_front());
        end
    end

    // Waits, with a cycle budget, until the chosen instance shows done.
    task automatic waitDone(input int inst, output int lat);
        lat = 0;
        while (!doneOf(inst) && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Issues one conversion, queues its expected result and checks latency.
    task automatic applyStimulus(input int inst, input logic [15:0] value, input exp_t expected);
        int lat;
        @(posedge clk);
        #1;
        case (inst)
            0:       begin bin_a = value;      start_a = 1'b1; q_a.push_back(expected); end
            1:       begin bin_u = value;      start_u = 1'b1; q_u.push_back(expected); end
            2:       begin bin_b = value[5:0]; start_b = 1'b1; q_b.push_back(expected); end
            default: begin bin_c = value[7:0]; start_c = 1'b1; q_c.push_back(expected); end
        endcase
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_u = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        waitDone(inst, lat);
        checkOutput($sformatf("latency inst %0d", inst), 32'(lat), 32'(widthOf(inst) + 1));
    endtask

    // Hard stop in case anything above stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int n;
        int cyc;
        int dcount;
        int t[3];

        rst = 1'b1;
        start_a = 1'b0; start_u = 1'b0; start_b = 1'b0; start_c = 1'b0;
        bin_a = '0; bin_u = '0; bin_b = '0; bin_c = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset busy",  32'(busy_a),  32'd0);
        checkOutput("reset done",  32'(done_a),  32'd0);
        checkOutput("reset bcd",   32'(bcd_a),   32'd0);
        checkOutput("reset sgn",   32'(sgn_a),   32'hF);
        checkOutput("reset blank", 32'(blank_a), 32'd0);
        checkOutput("reset ovf",   32'(ovf_a),   32'd0);

        applyStimulus(1, 16'hFFFF, mk(20'h65535, 4'hF, 5'b00000, 1'b0));

        applyStimulus(0, 16'd0,    mk(20'h00000, 4'hF, 5'b11110, 1'b0));
        applyStimulus(0, 16'd42,   mk(20'h00042, 4'hF, 5'b11100, 1'b0));
        applyStimulus(0, 16'hFFFF, mk(20'h00001, 4'hA, 5'b11110, 1'b0));
        applyStimulus(0, 16'h8000, mk(20'h32768, 4'hA, 5'b00000, 1'b0));

        applyStimulus(2, 16'h0020, mk(20'h00032, 4'hA, 5'b00000, 1'b0));
        applyStimulus(2, 16'h003F, mk(20'h00001, 4'hA, 5'b00010, 1'b0));

        applyStimulus(3, 16'd255,  mk(20'h00055, 4'hF, 5'b00000, 1'b1));
        applyStimulus(3, 16'd99,   mk(20'h00099, 4'hF, 5'b00000, 1'b0));
        applyStimulus(3, 16'd0,    mk(20'h00000, 4'hF, 5'b00010, 1'b0));

        // A start pulse carrying 100 while 7 is converting must be ignored.
        @(posedge clk);
        #1;
        bin_a = 16'd7;
        start_a = 1'b1;
        q_a.push_back(mk(20'h00007, 4'hF, 5'b11110, 1'b0));
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bin_a = 16'd100;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        bin_a = 16'd0;
        waitDone(0, lat);
        checkOutput("latency with ignored start", 32'(lat), 32'd12);
        repeat (25) @(posedge clk);

        // Start held high: the done cycle is idle, so the held start is taken
        // on the edge closing it and dones recur every WIDTH+2 edges.
        @(posedge clk);
        #1;
        bin_b = 6'd5;
        start_b = 1'b1;
        repeat (3) q_b.push_back(mk(20'h00005, 4'hF, 5'b00010, 1'b0));
        n = 0;
        cyc = 0;
        while (n < 3 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_b) begin
                t[n] = cyc;
                n++;
            end
        end
        start_b = 1'b0;
        checkOutput("held start done count", 32'(n), 32'd3);
        checkOutput("held start first latency", 32'(t[0] - 1), 32'd7);
        checkOutput("held start gap 1", 32'(t[1] - t[0]), 32'd8);
        checkOutput("held start gap 2", 32'(t[2] - t[1]), 32'd8);
        repeat (20) @(posedge clk);

        // Reset five cycles into a conversion: no done, outputs back to reset.
        @(posedge clk);
        #1;
        bin_a = 16'd1234;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort busy",  32'(busy_a),  32'd0);
        checkOutput("abort done",  32'(done_a),  32'd0);
        checkOutput("abort bcd",   32'(bcd_a),   32'd0);
        checkOutput("abort sgn",   32'(sgn_a),   32'hF);
        checkOutput("abort blank", 32'(blank_a), 32'd0);
        dcount = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done_a) dcount++;
        end
        checkOutput("no done after abort", 32'(dcount), 32'd0);

        applyStimulus(0, 16'd42, mk(20'h00042, 4'hF, 5'b11100, 1'b0));

        repeat (5) @(posedge clk);
        checkOutput("queue A drained", 32'(q_a.size()), 32'd0);
        checkOutput("queue U drained", 32'(q_u.size()), 32'd0);
        checkOutput("queue B drained", 32'(q_b.size()), 32'd0);
        checkOutput("queue C drained", 32'(q_c.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
